// File: rtl/laa_sched_if.sv
// Command channel from the core decode stage into the LAA scheduler.
// The master is the core side and the slave is the scheduler side.
interface laa_sched_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [4:0]        cmd_rs1;
  logic [4:0]        cmd_rs2;
  logic [4:0]        cmd_rd;
  logic [4:0]        cmd_core_rd;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_wdata;

  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_core_rd, cmd_len, cmd_wdata,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_core_rd, cmd_len, cmd_wdata,
    output cmd_ready
  );
endinterface

// File: rtl/laa_sched.sv
// LAA command scheduler: sequences READ, WRITE and MULTIPLY (dot product) commands
// over a single-port LAA register file with one-cycle read latency.
module laa_sched #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  laa_sched_if.slave        cmd_if,
  input  logic              flush_i,
  output logic [4:0]        rf_addr_o,
  output logic              rf_we_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;
  localparam logic [1:0] OpMul   = 2'd3;

  typedef enum logic [2:0] {
    StIdle, StWr, StRdAddr, StRdCap, StMacA, StMacB, StMacAcc, StStore
  } state_e;

  state_e            state_q;
  logic [4:0]        rs1_q, rs2_q, rd_q, core_rd_q;
  logic [LEN_W-1:0]  len_q, idx_q;
  logic [DATA_W-1:0] wdata_q, acc_q, a_q;
  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [4:0]        idx5;

  assign cmd_if.cmd_ready = (state_q == StIdle) && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      core_rd_q  <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      acc_q      <= '0;
      a_q        <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      if (flush_i) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cmd_if.cmd_valid) begin
              rs1_q     <= cmd_if.cmd_rs1;
              rs2_q     <= cmd_if.cmd_rs2;
              rd_q      <= cmd_if.cmd_rd;
              core_rd_q <= cmd_if.cmd_core_rd;
              len_q     <= cmd_if.cmd_len;
              wdata_q   <= cmd_if.cmd_wdata;
              acc_q     <= '0;
              idx_q     <= '0;
              unique case (cmd_if.cmd_op)
                OpWrite: state_q <= StWr;
                OpRead:  state_q <= StRdAddr;
                OpMul:   state_q <= StMacA;
                default: state_q <= StIdle;
              endcase
            end
          end
          StWr:     state_q <= StIdle;
          StRdAddr: state_q <= StRdCap;
          StRdCap: begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= core_rd_q;
            wb_data_q  <= rf_rdata_i;
            state_q    <= StIdle;
          end
          StMacA: state_q <= StMacB;
          StMacB: begin
            a_q     <= rf_rdata_i;
            state_q <= StMacAcc;
          end
          StMacAcc: begin
            acc_q <= acc_q + a_q * rf_rdata_i;
            if (idx_q == len_q) begin
              state_q <= StStore;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StMacA;
            end
          end
          StStore: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Write enable and retire pulses are gated by flush so an aborting cycle has no effect.
  always_comb begin
    rf_addr_o  = '0;
    rf_we_o    = 1'b0;
    rf_wdata_o = '0;
    idx5       = 5'(idx_q);
    unique case (state_q)
      StWr: begin
        rf_addr_o  = rd_q;
        rf_we_o    = !flush_i;
        rf_wdata_o = wdata_q;
      end
      StStore: begin
        rf_addr_o  = rd_q;
        rf_we_o    = !flush_i;
        rf_wdata_o = acc_q;
      end
      StRdAddr: rf_addr_o = rs1_q;
      StMacA:   rf_addr_o = rs1_q + idx5;
      StMacB:   rf_addr_o = rs2_q + idx5;
      default:  rf_addr_o = '0;
    endcase
  end

  assign wb_valid_o = wb_valid_q && !flush_i;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = ((state_q == StWr) || (state_q == StStore) || wb_valid_q) && !flush_i;

endmodule

// File: doc/laa_sched.md
LAA_SCHED -- requirements
Module: laa_sched

Interface
REQ-001 Parameter DATA_W, default 32, LAA register and datapath width.
REQ-002 Parameter LEN_W, default 4, width of MULTIPLY length field (vector length = cmd_len+1).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Rst  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command offered by core decode stage.
REQ-006 cmd_ready  out  1  scheduler accepts command this cycle.
REQ-007 cmd_op  in  2  0=NONE, 1=READ, 2=WRITE, 3=MULTIPLY.
REQ-008 cmd_rs1, cmd_rs2, cmd_rd  in  5 each  LAA register addresses.
REQ-009 cmd_core_rd  in  5  core destination register for READ.
REQ-010 cmd_len  in  LEN_W  MULTIPLY length minus one.
REQ-011 cmd_wdata  in  DATA_W  core rs1 data for WRITE.
REQ-012 flush  in  1  synchronous abort from core pipeline.
REQ-013 rf_addr  out  5; rf_we  out  1; rf_wdata  out  DATA_W; rf_rdata  in  DATA_W  LAA register file port, one port, read data valid the cycle after rf_addr is presented.
REQ-014 wb_valid  out  1; wb_rd  out  5; wb_data  out  DATA_W  core writeback, registered.
REQ-015 busy  out  1  stall request to core (state != IDLE).
REQ-016 done  out  1  one-cycle pulse when any non-NONE command retires.

Function
REQ-017 States: IDLE, WR, RD_ADDR, RD_CAP, MAC_A, MAC_B, MAC_ACC, STORE.
REQ-018 cmd_ready = 1 only in IDLE with flush=0; handshake = cmd_valid & cmd_ready at edge T; command fields latched at T.
REQ-019 NONE: accepted, no state change, no rf/wb activity, no done.
REQ-020 WRITE: cycle T+1 state WR, rf_we=1, rf_addr=rd, rf_wdata=wdata; done=1 at T+1; IDLE at T+2.
REQ-021 READ: T+1 RD_ADDR, rf_addr=rs1; T+2 RD_CAP, rf_rdata captured; T+3 wb_valid=1, wb_rd=core_rd, wb_data=captured value, done=1, state IDLE.
REQ-022 MULTIPLY: L=cmd_len+1; element i (0..L-1): MAC_A at T+1+3i (rf_addr=rs1+i), MAC_B at T+2+3i (rf_addr=rs2+i, capture A), MAC_ACC at T+3+3i (acc += A*rf_rdata).
REQ-023 Accumulator cleared on accept; product and sum truncated to low DATA_W bits (mod 2^DATA_W, unsigned).
REQ-024 Address arithmetic rs1+i, rs2+i is 5-bit, wraps 31->0.
REQ-025 STORE at T+1+3L: rf_we=1, rf_addr=rd, rf_wdata=acc, done=1; IDLE at T+2+3L; total latency 3L+1 cycles.
REQ-026 MULTIPLY never drives wb_valid; rd may alias rs1/rs2 (all reads complete before STORE).
REQ-027 rf_we=0 in every state except WR and STORE; rf_addr=0 when unused.
REQ-028 flush in any non-IDLE state: next state IDLE, no rf_we, no wb_valid, no done for the aborted command; flush asserted in the same cycle as a STORE/WR suppresses that write.
REQ-029 flush in IDLE blocks acceptance that cycle (cmd_ready=0).
REQ-030 busy=1 from T+1 until the cycle the state returns to IDLE.
REQ-031 wb_valid and done are single-cycle pulses; never asserted during flush.

Reset
REQ-032 Rst low asynchronously forces IDLE; cmd_ready=1 after release, busy=0, rf_we=0, rf_addr=0, rf_wdata=0, wb_valid=0, wb_rd=0, wb_data=0, done=0, accumulator and latched fields 0.
REQ-033 Reset mid-operation discards the command; no partial write or writeback after release.

Verification
REQ-034 WRITE rd=5, wdata=0xDEADBEEF -> rf_we at T+1 addr 5 data 0xDEADBEEF, done T+1, cmd_ready T+2.
REQ-035 Preload R3=0x1234; READ rs1=3 core_rd=10 -> wb_valid at T+3, wb_rd=10, wb_data=0x1234, busy T+1..T+2.
REQ-036 R0..R3={1,2,3,4}, R4..R7={5,6,7,8}; MULTIPLY rs1=0 rs2=4 rd=9 len=3 -> STORE at T+13, R9=70, done once.
REQ-037 Wrap: rs1=30, len=3 -> reads addresses 30,31,0,1; R=0xFFFFFFFF*0xFFFFFFFF single element -> result 0x00000001.
REQ-038 flush at T+5 of MULTIPLY -> IDLE at T+6, no rf_we, no done; new WRITE accepted next cycle completes normally.
REQ-039 Rst low at T+4 of MULTIPLY -> outputs zero immediately, rd unchanged, cmd_ready=1 after release.
